// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Sequencing FSM for the multi-cycle RISC-V datapath. One ALU and
//            one unified instruction/data memory port are shared across the
//            fetch, decode, execute, memory and write-back steps. This block
//            generates every per-cycle select and write-enable from the
//            current state, the IR opcode and two status inputs.
// Ports    : clk            - system clock, rising edge
//            reset          - asynchronous active-low reset
//            Opcode_i       - IR[6:0], stable from DECODE until next FETCH
//            Mem_Ready_i    - memory completes the current access this cycle
//            Branch_Taken_i - ALU compare result, used only in BRANCH
//            PC_Write_o / PC_Src_o / IR_Write_o / Adr_Src_o / Mem_Req_o /
//            Mem_Write_o / Reg_Write_o / Result_Src_o / ALU_Src_A_o /
//            ALU_Src_B_o / ALU_Op_o / Branch_o / Illegal_o / Retire_o
//                           - datapath controls and status pulses
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode_i,
  input  logic       Mem_Ready_i,
  input  logic       Branch_Taken_i,
  output logic       PC_Write_o,
  output logic       PC_Src_o,
  output logic       IR_Write_o,
  output logic       Adr_Src_o,
  output logic       Mem_Req_o,
  output logic       Mem_Write_o,
  output logic       Reg_Write_o,
  output logic [1:0] Result_Src_o,
  output logic [1:0] ALU_Src_A_o,
  output logic [1:0] ALU_Src_B_o,
  output logic [2:0] ALU_Op_o,
  output logic       Branch_o,
  output logic       Illegal_o,
  output logic       Retire_o
);

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_LUI  = 7'h37;
  localparam logic [6:0] OP_LW   = 7'h03;
  localparam logic [6:0] OP_SW   = 7'h23;
  localparam logic [6:0] OP_B    = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;

  localparam logic [2:0] ALUOP_R   = 3'b000;
  localparam logic [2:0] ALUOP_I   = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b100;
  localparam logic [2:0] ALUOP_BR  = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_EXEC_U    = 4'd9,
    S_ALU_WB    = 4'd10,
    S_BRANCH    = 4'd11,
    S_JALR_ADDR = 4'd12,
    S_LINK      = 4'd13
  } state_t;

  state_t state_q, state_d;

  // Asynchronous reset forces IDLE at once; since every output is decoded
  // combinationally from the state, all outputs drop in the same cycle,
  // aborting any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    PC_Write_o   = 1'b0;
    PC_Src_o     = 1'b0;
    IR_Write_o   = 1'b0;
    Adr_Src_o    = 1'b0;
    Mem_Req_o    = 1'b0;
    Mem_Write_o  = 1'b0;
    Reg_Write_o  = 1'b0;
    Result_Src_o = 2'b00;
    ALU_Src_A_o  = 2'b00;
    ALU_Src_B_o  = 2'b00;
    ALU_Op_o     = 3'b000;
    Branch_o     = 1'b0;
    Illegal_o    = 1'b0;
    Retire_o     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        Mem_Req_o = 1'b1;
        // PC+4 goes straight from the ALU to the PC on the ready cycle.
        if (Mem_Ready_i) begin
          IR_Write_o   = 1'b1;
          PC_Write_o   = 1'b1;
          ALU_Src_B_o  = 2'b10;
          ALU_Op_o     = ALUOP_ADD;
          Result_Src_o = 2'b10;
          state_d      = S_DECODE;
        end
      end

      S_DECODE: begin
        // OldPC + imm is precomputed into ALUOut for branch/JAL targets.
        ALU_Src_A_o = 2'b01;
        ALU_Src_B_o = 2'b01;
        ALU_Op_o    = ALUOP_ADD;
        case (Opcode_i)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_LUI:       state_d = S_EXEC_U;
          OP_B:         state_d = S_BRANCH;
          OP_JAL:       state_d = S_LINK;
          OP_JALR:      state_d = S_JALR_ADDR;
          default: begin
            Illegal_o = 1'b1;
            Retire_o  = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end

      S_MEM_ADDR: begin
        ALU_Src_A_o = 2'b10;
        ALU_Src_B_o = 2'b01;
        ALU_Op_o    = ALUOP_ADD;
        state_d     = (Opcode_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        Adr_Src_o = 1'b1;
        Mem_Req_o = 1'b1;
        if (Mem_Ready_i) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        Result_Src_o = 2'b01;
        Reg_Write_o  = 1'b1;
        Retire_o     = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEM_WRITE: begin
        Adr_Src_o   = 1'b1;
        Mem_Req_o   = 1'b1;
        Mem_Write_o = 1'b1;
        if (Mem_Ready_i) begin
          Retire_o = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_EXEC_R: begin
        ALU_Src_A_o = 2'b10;
        ALU_Src_B_o = 2'b00;
        ALU_Op_o    = ALUOP_R;
        state_d     = S_ALU_WB;
      end

      S_EXEC_I: begin
        ALU_Src_A_o = 2'b10;
        ALU_Src_B_o = 2'b01;
        ALU_Op_o    = ALUOP_I;
        state_d     = S_ALU_WB;
      end

      // LUI is computed as zero + imm through the I-logic ALU path.
      S_EXEC_U: begin
        ALU_Src_A_o = 2'b11;
        ALU_Src_B_o = 2'b01;
        ALU_Op_o    = ALUOP_I;
        state_d     = S_ALU_WB;
      end

      S_ALU_WB: begin
        Reg_Write_o = 1'b1;
        Retire_o    = 1'b1;
        state_d     = S_FETCH;
      end

      S_BRANCH: begin
        ALU_Src_A_o = 2'b10;
        ALU_Src_B_o = 2'b00;
        ALU_Op_o    = ALUOP_BR;
        Branch_o    = 1'b1;
        PC_Src_o    = 1'b1;
        PC_Write_o  = Branch_Taken_i;
        Retire_o    = 1'b1;
        state_d     = S_FETCH;
      end

      S_JALR_ADDR: begin
        ALU_Src_A_o = 2'b10;
        ALU_Src_B_o = 2'b01;
        ALU_Op_o    = ALUOP_ADD;
        state_d     = S_LINK;
      end

      // Link value OldPC+4 is written to rd while the PC loads the target
      // already held in ALUOut (from DECODE for JAL, JALR_ADDR for JALR).
      S_LINK: begin
        ALU_Src_A_o  = 2'b01;
        ALU_Src_B_o  = 2'b10;
        ALU_Op_o     = ALUOP_ADD;
        Result_Src_o = 2'b10;
        Reg_Write_o  = 1'b1;
        PC_Write_o   = 1'b1;
        PC_Src_o     = 1'b1;
        Retire_o     = 1'b1;
        state_d      = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed self-checking bench for multicycle_control. Each task
//            walks one instruction class cycle by cycle and compares the
//            packed output vector with hand-written expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [6:0] Opcode_i;
  logic       Mem_Ready_i;
  logic       Branch_Taken_i;
  logic       PC_Write_o, PC_Src_o, IR_Write_o, Adr_Src_o, Mem_Req_o;
  logic       Mem_Write_o, Reg_Write_o, Branch_o, Illegal_o, Retire_o;
  logic [1:0] Result_Src_o, ALU_Src_A_o, ALU_Src_B_o;
  logic [2:0] ALU_Op_o;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_control dut (
    .clk            (clk),
    .reset          (reset),
    .Opcode_i       (Opcode_i),
    .Mem_Ready_i    (Mem_Ready_i),
    .Branch_Taken_i (Branch_Taken_i),
    .PC_Write_o     (PC_Write_o),
    .PC_Src_o       (PC_Src_o),
    .IR_Write_o     (IR_Write_o),
    .Adr_Src_o      (Adr_Src_o),
    .Mem_Req_o      (Mem_Req_o),
    .Mem_Write_o    (Mem_Write_o),
    .Reg_Write_o    (Reg_Write_o),
    .Result_Src_o   (Result_Src_o),
    .ALU_Src_A_o    (ALU_Src_A_o),
    .ALU_Src_B_o    (ALU_Src_B_o),
    .ALU_Op_o       (ALU_Op_o),
    .Branch_o       (Branch_o),
    .Illegal_o      (Illegal_o),
    .Retire_o       (Retire_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Order: pcw pcs irw adr req mw rw rs[2] a[2] b[2] op[3] br ill ret
  logic [18:0] outs;
  assign outs = {PC_Write_o, PC_Src_o, IR_Write_o, Adr_Src_o, Mem_Req_o,
                 Mem_Write_o, Reg_Write_o, Result_Src_o, ALU_Src_A_o,
                 ALU_Src_B_o, ALU_Op_o, Branch_o, Illegal_o, Retire_o};

  localparam logic [18:0] E_IDLE      = 19'd0;
  localparam logic [18:0] E_FETCH_W   = {7'b0000100, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
  localparam logic [18:0] E_FETCH_R   = {7'b1010100, 2'b10, 2'b00, 2'b10, 3'b100, 3'b000};
  localparam logic [18:0] E_DECODE    = {7'b0000000, 2'b00, 2'b01, 2'b01, 3'b100, 3'b000};
  localparam logic [18:0] E_DECODE_IL = {7'b0000000, 2'b00, 2'b01, 2'b01, 3'b100, 3'b011};
  localparam logic [18:0] E_MEM_ADDR  = {7'b0000000, 2'b00, 2'b10, 2'b01, 3'b100, 3'b000};
  localparam logic [18:0] E_MEM_READ  = {7'b0001100, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
  localparam logic [18:0] E_MEM_WB    = {7'b0000001, 2'b01, 2'b00, 2'b00, 3'b000, 3'b001};
  localparam logic [18:0] E_MEM_WR_W  = {7'b0001110, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
  localparam logic [18:0] E_MEM_WR_R  = {7'b0001110, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001};
  localparam logic [18:0] E_EXEC_R    = {7'b0000000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000};
  localparam logic [18:0] E_EXEC_I    = {7'b0000000, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000};
  localparam logic [18:0] E_EXEC_U    = {7'b0000000, 2'b00, 2'b11, 2'b01, 3'b001, 3'b000};
  localparam logic [18:0] E_ALU_WB    = {7'b0000001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001};
  localparam logic [18:0] E_BR_T      = {7'b1100000, 2'b00, 2'b10, 2'b00, 3'b101, 3'b101};
  localparam logic [18:0] E_BR_NT     = {7'b0100000, 2'b00, 2'b10, 2'b00, 3'b101, 3'b101};
  localparam logic [18:0] E_JALR_ADDR = {7'b0000000, 2'b00, 2'b10, 2'b01, 3'b100, 3'b000};
  localparam logic [18:0] E_LINK      = {7'b1100001, 2'b10, 2'b01, 2'b10, 3'b100, 3'b001};

  // Each task starts just after a rising edge with the DUT in FETCH.

  task automatic test_reset;
    reset = 1'b0; Mem_Ready_i = 1'b0; Branch_Taken_i = 1'b0; Opcode_i = 7'h00;
    #2;
    n_checks++;
    if (outs !== E_IDLE) $display("FAIL reset_state: got %b expected %b", outs, E_IDLE);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs !== E_IDLE) $display("FAIL reset_idle: got %b expected %b", outs, E_IDLE);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (outs !== E_FETCH_W) $display("FAIL reset_fetch: got %b expected %b", outs, E_FETCH_W);
    else n_pass++;
  endtask

  task automatic test_r_type;
    logic [18:0] ex[$] = '{E_FETCH_R, E_DECODE, E_EXEC_R, E_ALU_WB};
    Opcode_i = 7'h33; Mem_Ready_i = 1'b1;
    foreach (ex[i]) begin
      @(negedge clk);
      n_checks++;
      if (outs !== ex[i]) $display("FAIL r_type cyc%0d: got %b expected %b", i, outs, ex[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_i_lui;
    logic [18:0] ex[$] = '{E_FETCH_R, E_DECODE, E_EXEC_I, E_ALU_WB,
                           E_FETCH_R, E_DECODE, E_EXEC_U, E_ALU_WB};
    Mem_Ready_i = 1'b1;
    foreach (ex[i]) begin
      Opcode_i = (i < 4) ? 7'h13 : 7'h37;
      @(negedge clk);
      n_checks++;
      if (outs !== ex[i]) $display("FAIL i_lui cyc%0d: got %b expected %b", i, outs, ex[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait;
    logic [18:0] ex[$]  = '{E_FETCH_R, E_DECODE, E_MEM_ADDR, E_MEM_READ,
                            E_MEM_READ, E_MEM_READ, E_MEM_READ, E_MEM_WB};
    logic        rdy[$] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    Opcode_i = 7'h03;
    foreach (ex[i]) begin
      Mem_Ready_i = rdy[i];
      @(negedge clk);
      n_checks++;
      if (outs !== ex[i]) $display("FAIL lw_wait cyc%0d: got %b expected %b", i, outs, ex[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_wait;
    logic [18:0] ex[$]  = '{E_FETCH_W, E_FETCH_R, E_DECODE, E_MEM_ADDR,
                            E_MEM_WR_W, E_MEM_WR_R};
    logic        rdy[$] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    Opcode_i = 7'h23;
    foreach (ex[i]) begin
      Mem_Ready_i = rdy[i];
      @(negedge clk);
      n_checks++;
      if (outs !== ex[i]) $display("FAIL sw_wait cyc%0d: got %b expected %b", i, outs, ex[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch;
    logic [18:0] ex[$] = '{E_FETCH_R, E_DECODE, E_BR_T, E_FETCH_R, E_DECODE, E_BR_NT};
    Opcode_i = 7'h63; Mem_Ready_i = 1'b1;
    foreach (ex[i]) begin
      Branch_Taken_i = (i < 3);
      @(negedge clk);
      n_checks++;
      if (outs !== ex[i]) $display("FAIL branch cyc%0d: got %b expected %b", i, outs, ex[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
    Branch_Taken_i = 1'b0;
  endtask

  task automatic test_jal_jalr;
    logic [18:0] ex[$] = '{E_FETCH_R, E_DECODE, E_LINK,
                           E_FETCH_R, E_DECODE, E_JALR_ADDR, E_LINK};
    Mem_Ready_i = 1'b1;
    foreach (ex[i]) begin
      Opcode_i = (i < 3) ? 7'h6F : 7'h67;
      @(negedge clk);
      n_checks++;
      if (outs !== ex[i]) $display("FAIL jal_jalr cyc%0d: got %b expected %b", i, outs, ex[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal;
    logic [18:0] ex[$]  = '{E_FETCH_R, E_DECODE_IL, E_FETCH_W};
    logic        rdy[$] = '{1'b1, 1'b1, 1'b0};
    Opcode_i = 7'h7F;
    foreach (ex[i]) begin
      Mem_Ready_i = rdy[i];
      @(negedge clk);
      n_checks++;
      if (outs !== ex[i]) $display("FAIL illegal cyc%0d: got %b expected %b", i, outs, ex[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  // Leaves the DUT in FETCH (held by Mem_Ready_i=0) from test_illegal.
  task automatic test_reset_mid_read;
    logic [18:0] ex[$]  = '{E_FETCH_R, E_DECODE, E_MEM_ADDR, E_MEM_READ};
    logic        rdy[$] = '{1'b1, 1'b1, 1'b1, 1'b0};
    Opcode_i = 7'h03;
    foreach (ex[i]) begin
      Mem_Ready_i = rdy[i];
      @(negedge clk);
      n_checks++;
      if (outs !== ex[i]) $display("FAIL rst_mid cyc%0d: got %b expected %b", i, outs, ex[i]);
      else n_pass++;
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (outs !== E_IDLE) $display("FAIL rst_mid_abort: got %b expected %b", outs, E_IDLE);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs !== E_IDLE) $display("FAIL rst_mid_idle: got %b expected %b", outs, E_IDLE);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (outs !== E_FETCH_W) $display("FAIL rst_mid_fetch: got %b expected %b", outs, E_FETCH_W);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    // Still in FETCH with ready low; release it into the instruction tests.
    @(posedge clk); #1;
    test_r_type;
    test_i_lui;
    test_lw_wait;
    test_sw_wait;
    test_branch;
    test_jal_jalr;
    test_illegal;
    test_reset_mid_read;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

- Sequencing FSM for the multi-cycle RISC-V datapath:
  - shares one ALU and one unified instruction/data memory port across fetch, decode, execute, memory and write-back steps;
  - generates every per-cycle select and write-enable.
- Takes the opcode from the instruction register plus two status inputs: memory ready and branch taken.
- Replaces the single-cycle decoder for the multi-cycle build, and keeps the team's ALU_Op encoding so the ALU decoder is unchanged.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Opcode_i  in  7  IR[6:0]; stable from the DECODE cycle until the next FETCH
- Mem_Ready_i  in  1  memory completes the current access this cycle
- Branch_Taken_i  in  1  branch condition from the ALU compare, valid in BRANCH
- PC_Write_o  out  1  load PC
- PC_Src_o  out  1  0 = result bus, 1 = ALUOut register
- IR_Write_o  out  1  load IR and OldPC
- Adr_Src_o  out  1  memory address: 0 = PC, 1 = ALUOut
- Mem_Req_o  out  1  memory access request
- Mem_Write_o  out  1  access is a write (only with Mem_Req_o)
- Reg_Write_o  out  1  register-file write
- Result_Src_o  out  2  00 = ALUOut, 01 = memory data register, 10 = ALU result direct
- ALU_Src_A_o  out  2  00 = PC, 01 = OldPC, 10 = rs1 register A, 11 = zero
- ALU_Src_B_o  out  2  00 = rs2 register B, 01 = immediate, 10 = constant 4
- ALU_Op_o  out  3  000 = R-type, 001 = I-logic/LUI, 100 = add, 101 = branch compare
- Branch_o  out  1  BRANCH state indicator
- Illegal_o  out  1  one-cycle pulse on an unsupported opcode
- Retire_o  out  1  one-cycle pulse in the final cycle of each instruction

## Operation
- Opcodes: R 0x33, I-logic 0x13, LUI 0x37, LW 0x03, SW 0x23, B 0x63, JAL 0x6F, JALR 0x67.
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, EXEC_U, ALU_WB, BRANCH, JALR_ADDR, LINK.
- Any output not listed for a state is 0.
- IDLE: all outputs 0. Goes to FETCH unconditionally.
- FETCH: Adr_Src=0, Mem_Req=1.
  - Held while Mem_Ready_i=0.
  - On ready: IR_Write=1, PC_Write=1, PC_Src=0, A=00, B=10, op=100, Result_Src=10. Goes to DECODE.
- DECODE: A=01, B=01, op=100 (branch/JAL target into ALUOut). Dispatch on Opcode_i:
  - 0x03 or 0x23 → MEM_ADDR
  - 0x33 → EXEC_R
  - 0x13 → EXEC_I
  - 0x37 → EXEC_U
  - 0x63 → BRANCH
  - 0x6F → LINK
  - 0x67 → JALR_ADDR
  - any other opcode → FETCH, with Illegal_o=1 and Retire_o=1. No register or memory write occurs.
- MEM_ADDR: A=10, B=01, op=100. Goes to MEM_READ if the opcode is 0x03, else MEM_WRITE.
- MEM_READ: Adr_Src=1, Mem_Req=1. Held until ready, then goes to MEM_WB.
- MEM_WB: Result_Src=01, Reg_Write=1, Retire=1. Goes to FETCH.
- MEM_WRITE: Adr_Src=1, Mem_Req=1, Mem_Write=1. Held until ready; Retire=1 on the ready cycle. Goes to FETCH.
- EXEC_R: A=10, B=00, op=000. Goes to ALU_WB.
- EXEC_I: A=10, B=01, op=001. Goes to ALU_WB.
- EXEC_U: A=11, B=01, op=001. Goes to ALU_WB.
- ALU_WB: Result_Src=00, Reg_Write=1, Retire=1. Goes to FETCH.
- BRANCH: A=10, B=00, op=101, Branch=1, PC_Src=1, PC_Write=Branch_Taken_i, Retire=1. Goes to FETCH.
- JALR_ADDR: A=10, B=01, op=100 (rs1+imm into ALUOut). Goes to LINK.
- LINK: A=01, B=10, op=100, Result_Src=10, Reg_Write=1, PC_Write=1, PC_Src=1, Retire=1. Goes to FETCH.
- Output types:
  - Moore outputs: decoded from state only.
  - Gated by inputs: IR_Write, PC_Write (FETCH), Retire (MEM_WRITE) by Mem_Ready_i; PC_Write (BRANCH) by Branch_Taken_i.

## Timing
- Reset assertion is asynchronous: state goes to IDLE and all outputs go to 0 immediately. This includes mid-access, which drops Mem_Req_o and aborts the access.
- After reset is deasserted: one IDLE cycle, then FETCH.
- Latency with zero-wait memory, in cycles from FETCH entry through the Retire cycle:
  - R / I / LUI: 4
  - LW: 5
  - SW: 4
  - BRANCH: 3
  - JAL: 3
  - JALR: 4
  - illegal opcode: 2
- Each wait cycle in FETCH, MEM_READ or MEM_WRITE adds exactly 1 cycle.
- While waiting, Mem_Req_o, Adr_Src_o and Mem_Write_o stay constant and no write strobe is asserted.
- Mem_Ready_i is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Branch_Taken_i is ignored outside BRANCH.
- At most one of Reg_Write_o and Mem_Write_o is high in any cycle.
- Retire_o is high exactly once per instruction.

## Test plan
- Reset low mid-MEM_READ with Mem_Ready_i=0 → all outputs 0 in the same cycle. After release: one IDLE cycle, FETCH with Mem_Req_o=1.
- Opcode 0x33, zero-wait memory → state sequence FETCH, DECODE, EXEC_R, ALU_WB:
  - ALU_Op_o=000 in EXEC_R;
  - Reg_Write_o=1 only in cycle 4;
  - Retire_o pulses in cycle 4.
- Opcode 0x03 with Mem_Ready_i low for 3 cycles in MEM_READ → 8 cycles total; Mem_Req_o=1, Adr_Src_o=1 held throughout the wait; Result_Src_o=01 in MEM_WB.
- Opcode 0x63, Branch_Taken_i=1, then repeat with 0 → PC_Write_o=1 and 0 respectively in BRANCH; PC_Src_o=1 and Branch_o=1 in both runs.
- Opcode 0x67 → JALR_ADDR (A=10, B=01), then LINK (A=01, B=10, Reg_Write_o=1, PC_Write_o=1, PC_Src_o=1).
- Opcode 0x7F → Illegal_o=1 and Retire_o=1 in DECODE, then FETCH; no Reg_Write_o or Mem_Write_o at any point.
